// File: rtl/rvh_pmp_pkg.sv
// Shared PMP definitions used by the check arbiter and by the PMP entries.
// Contents:
//   acc_type_e      - access type encoding driven onto the check bus (R/W/X)
//   ReqItlb/Dtlb/Ptw - requester index constants
//   id_width()      - width of a requester index, never narrower than one bit
package rvh_pmp_pkg;

  typedef enum logic [1:0] {
    AccR = 2'd0,
    AccW = 2'd1,
    AccX = 2'd2
  } acc_type_e;

  localparam int unsigned ReqItlb = 0;
  localparam int unsigned ReqDtlb = 1;
  localparam int unsigned ReqPtw  = 2;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rvh_pmp_rr_arb.sv
// Round-robin arbiter with a registered search pointer.
// Ports:
//   clk, rstn  - clock, synchronous active-low reset (pointer returns to 0)
//   req_i      - per-requester request
//   en_i       - grant enable; no grant and no pointer move when low
//   gnt_o      - one-hot grant (or zero)
//   gnt_idx_o  - index of the granted requester (0 when nothing is granted)
// The search starts at the pointer; after a grant the pointer moves to the
// granted index + 1 (wrapping at N). A grant always implies a handshake.
module rvh_pmp_rr_arb
  import rvh_pmp_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [N-1:0]              req_i,
  input  logic                      en_i,
  output logic [N-1:0]              gnt_o,
  output logic [id_width(N)-1:0]    gnt_idx_o
);

  localparam int unsigned IdxW = id_width(N);

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin : p_search
    int unsigned idx;
    logic        found;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = 32'(rr_ptr_q) + off;
      if (idx >= N) idx = idx - N;
      if (en_i && !found && req_i[idx]) begin
        found          = 1'b1;
        gnt_o[idx]     = 1'b1;
        gnt_idx_o      = IdxW'(idx);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|gnt_o) begin
      rr_ptr_d = (32'(gnt_idx_o) + 1 >= N) ? '0 : IdxW'(32'(gnt_idx_o) + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/rvh_pmp_check_arb.sv
// PMP check arbiter: picks one of REQ_NUM requesters (ITLB/DTLB/PTW) per
// cycle, broadcasts the accepted address to all PMP entries (stage S1),
// resolves the entry responses into a fault bit and returns it (stage S2).
// Ports:
//   clk, rstn            - clock, synchronous active-low reset
//   flush_i              - drop both pipeline stages, accept nothing
//   req_*                - packed per-requester request bus (valid/ready)
//   check_*              - broadcast to PMP entries, driven from S1 only
//   entry_*              - per-entry match/fail/lock/active from the entries
//   resp_*               - response (valid/ready) with requester id and fault
// Latency is two cycles from handshake to resp_vld_o with full throughput.
module rvh_pmp_check_arb
  import rvh_pmp_pkg::*;
#(
  parameter int unsigned PADDR_WIDTH     = 56,
  parameter int unsigned REQ_NUM         = 3,
  parameter int unsigned PMP_ENTRY_COUNT = 16
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             flush_i,
  input  logic [REQ_NUM-1:0]               req_vld_i,
  output logic [REQ_NUM-1:0]               req_rdy_o,
  input  logic [REQ_NUM*PADDR_WIDTH-1:0]   req_paddr_i,
  input  logic [2*REQ_NUM-1:0]             req_access_type_i,
  input  logic [REQ_NUM-1:0]               req_priv_m_i,
  output logic                             check_vld_o,
  output logic [PADDR_WIDTH-1:0]           check_paddr_o,
  output logic [1:0]                       check_access_type_o,
  input  logic [PMP_ENTRY_COUNT-1:0]       entry_match_i,
  input  logic [PMP_ENTRY_COUNT-1:0]       entry_fail_i,
  input  logic [PMP_ENTRY_COUNT-1:0]       entry_locked_i,
  input  logic [PMP_ENTRY_COUNT-1:0]       entry_active_i,
  output logic                             resp_vld_o,
  input  logic                             resp_rdy_i,
  output logic [id_width(REQ_NUM)-1:0]     resp_id_o,
  output logic                             resp_fault_o
);

  localparam int unsigned IdW = id_width(REQ_NUM);

  // Stage S1: request being checked against the entries
  logic                   s1_vld_q;
  logic [PADDR_WIDTH-1:0] s1_paddr_q;
  acc_type_e              s1_type_q;
  logic                   s1_priv_m_q;
  logic [IdW-1:0]         s1_id_q;
  // Stage S2: resolved response
  logic                   s2_vld_q;
  logic [IdW-1:0]         s2_id_q;
  logic                   s2_fault_q;

  logic                   s2_free, s1_free, arb_en, hs;
  logic [REQ_NUM-1:0]     gnt;
  logic [IdW-1:0]         gnt_idx;
  logic [PADDR_WIDTH-1:0] sel_paddr;
  acc_type_e              sel_type;
  logic                   sel_priv_m;
  logic                   hit, hit_fail, hit_locked, fault;

  assign s2_free = ~s2_vld_q | resp_rdy_i;
  assign s1_free = ~s1_vld_q | s2_free;
  assign arb_en  = rstn & ~flush_i & s1_free;
  assign hs      = |gnt;

  rvh_pmp_rr_arb #(
    .N (REQ_NUM)
  ) u_rr_arb (
    .clk       (clk),
    .rstn      (rstn),
    .req_i     (req_vld_i),
    .en_i      (arb_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    sel_paddr  = '0;
    sel_type   = AccR;
    sel_priv_m = 1'b0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      if (gnt[i]) begin
        sel_paddr  = req_paddr_i[i*PADDR_WIDTH +: PADDR_WIDTH];
        sel_type   = acc_type_e'(req_access_type_i[2*i +: 2]);
        sel_priv_m = req_priv_m_i[i];
      end
    end
  end

  // Lowest-index match wins: scan downward so the last hit written is the lowest.
  always_comb begin
    hit        = 1'b0;
    hit_fail   = 1'b0;
    hit_locked = 1'b0;
    for (int i = int'(PMP_ENTRY_COUNT) - 1; i >= 0; i--) begin
      if (entry_match_i[i]) begin
        hit        = 1'b1;
        hit_fail   = entry_fail_i[i];
        hit_locked = entry_locked_i[i];
      end
    end
    // M-mode bypasses unlocked entries; with no match only M-mode or an
    // all-OFF table is allowed through.
    if (hit) fault = hit_fail & (~s1_priv_m_q | hit_locked);
    else     fault = ~s1_priv_m_q & (|entry_active_i);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_vld_q    <= 1'b0;
      s1_paddr_q  <= '0;
      s1_type_q   <= AccR;
      s1_priv_m_q <= 1'b0;
      s1_id_q     <= '0;
      s2_vld_q    <= 1'b0;
      s2_id_q     <= '0;
      s2_fault_q  <= 1'b0;
    end else if (flush_i) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      if (s2_free) begin
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          s2_id_q    <= s1_id_q;
          s2_fault_q <= fault;
        end
      end
      if (hs) begin
        s1_vld_q    <= 1'b1;
        s1_paddr_q  <= sel_paddr;
        s1_type_q   <= sel_type;
        s1_priv_m_q <= sel_priv_m;
        s1_id_q     <= gnt_idx;
      end else if (s2_free) begin
        s1_vld_q <= 1'b0;
      end
    end
  end

  // Outputs are forced low while reset is held so nothing leaks before the
  // first reset edge has cleared the registers.
  assign req_rdy_o           = gnt;
  assign check_vld_o         = rstn & s1_vld_q;
  assign check_paddr_o       = rstn ? s1_paddr_q : '0;
  assign check_access_type_o = rstn ? s1_type_q : 2'b00;
  assign resp_vld_o          = rstn & s2_vld_q;
  assign resp_id_o           = rstn ? s2_id_q : '0;
  assign resp_fault_o        = rstn & s2_fault_q;

endmodule

// File: tb/tb_rvh_pmp_check_arb.sv
module tb_rvh_pmp_check_arb;
  import rvh_pmp_pkg::*;

  localparam int unsigned PW = 56;
  localparam int unsigned RN = 3;
  localparam int unsigned NE = 16;

  logic           clk = 1'b0;
  logic           rstn, flush, resp_rdy;
  logic [RN-1:0]  req_vld, req_rdy, req_priv;
  logic [RN*PW-1:0] req_paddr;
  logic [2*RN-1:0] req_type;
  logic           check_vld, resp_vld, resp_fault;
  logic [PW-1:0]  check_paddr;
  logic [1:0]     check_type, resp_id;
  logic [NE-1:0]  e_match, e_fail, e_lock, e_active;

  always #5 clk = ~clk;

  rvh_pmp_check_arb #(
    .PADDR_WIDTH     (PW),
    .REQ_NUM         (RN),
    .PMP_ENTRY_COUNT (NE)
  ) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .flush_i             (flush),
    .req_vld_i           (req_vld),
    .req_rdy_o           (req_rdy),
    .req_paddr_i         (req_paddr),
    .req_access_type_i   (req_type),
    .req_priv_m_i        (req_priv),
    .check_vld_o         (check_vld),
    .check_paddr_o       (check_paddr),
    .check_access_type_o (check_type),
    .entry_match_i       (e_match),
    .entry_fail_i        (e_fail),
    .entry_locked_i      (e_lock),
    .entry_active_i      (e_active),
    .resp_vld_o          (resp_vld),
    .resp_rdy_i          (resp_rdy),
    .resp_id_o           (resp_id),
    .resp_fault_o        (resp_fault)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level reference: one slot being checked, one slot answering.
  int            m_rr;
  bit            m_s1_v, m_s2_v, m_s1_priv, m_s2_fault;
  logic [PW-1:0] m_s1_paddr;
  logic [1:0]    m_s1_type;
  int            m_s1_id, m_s2_id;
  logic [RN-1:0] exp_rdy;
  int            exp_gidx;

  function automatic bit ref_fault(input bit priv, input logic [NE-1:0] m, input logic [NE-1:0] f,
                                   input logic [NE-1:0] l, input logic [NE-1:0] a);
    for (int i = 0; i < NE; i++) if (m[i]) return f[i] && (!priv || l[i]);
    return !priv && (a != 0);
  endfunction

  task automatic model_eval();
    int idx;
    exp_rdy  = '0;
    exp_gidx = -1;
    if (rstn && !flush && (!m_s1_v || !m_s2_v || resp_rdy)) begin
      for (int k = 0; k < RN; k++) begin
        idx = (m_rr + k) % RN;
        if (exp_gidx < 0 && req_vld[idx]) exp_gidx = idx;
      end
    end
    if (exp_gidx >= 0) exp_rdy[exp_gidx] = 1'b1;
  endtask

  task automatic model_step();
    bit out_free;
    model_eval();
    out_free = !m_s2_v || resp_rdy;
    if (!rstn) begin
      m_s1_v = 0; m_s2_v = 0; m_rr = 0;
    end else if (flush) begin
      m_s1_v = 0; m_s2_v = 0;
    end else begin
      if (out_free) begin
        if (m_s1_v) begin
          m_s2_id    = m_s1_id;
          m_s2_fault = ref_fault(m_s1_priv, e_match, e_fail, e_lock, e_active);
        end
        m_s2_v = m_s1_v;
        m_s1_v = 0;
      end
      if (exp_gidx >= 0) begin
        m_s1_v     = 1;
        m_s1_paddr = req_paddr[exp_gidx*PW +: PW];
        m_s1_type  = req_type[2*exp_gidx +: 2];
        m_s1_priv  = req_priv[exp_gidx];
        m_s1_id    = exp_gidx;
        m_rr       = (exp_gidx + 1) % RN;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 0; req_vld = '0; flush = 0; resp_rdy = 1;
    tick(); tick();
    rstn = 1;
  endtask

  task automatic send_one(input int id, input logic [1:0] typ, input logic pm);
    req_vld = '0;
    req_vld[id] = 1'b1;
    req_type[2*id +: 2] = typ;
    req_priv[id] = pm;
    tick();
    req_vld = '0;
    tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 0; req_vld = '1; resp_rdy = 1; e_match = '1; e_active = '1;
    tick(); tick();
    @(negedge clk);
    n_checks++; if (req_rdy !== 3'b000) begin n_errors++; $display("FAIL reset_rdy got %b want 000", req_rdy); end
    n_checks++; if (check_vld !== 1'b0) begin n_errors++; $display("FAIL reset_check_vld got %b want 0", check_vld); end
    n_checks++; if (resp_vld !== 1'b0) begin n_errors++; $display("FAIL reset_resp_vld got %b want 0", resp_vld); end
    n_checks++; if (resp_fault !== 1'b0) begin n_errors++; $display("FAIL reset_fault got %b want 0", resp_fault); end
    n_checks++; if (resp_id !== 2'd0) begin n_errors++; $display("FAIL reset_id got %0d want 0", resp_id); end
    n_checks++; if (check_paddr !== '0) begin n_errors++; $display("FAIL reset_paddr got %h want 0", check_paddr); end
    n_checks++; if (check_type !== 2'd0) begin n_errors++; $display("FAIL reset_type got %0d want 0", check_type); end
    rstn = 1; req_vld = '0; e_match = '0; e_active = '0;
    tick();
    @(negedge clk);
    n_checks++; if (check_vld !== 1'b0 || resp_vld !== 1'b0) begin
      n_errors++; $display("FAIL post_reset_vld got %b%b want 00", check_vld, resp_vld); end
  endtask

  task automatic test_single_dtlb();
    do_reset();
    req_paddr[ReqDtlb*PW +: PW] = 56'h8000_0000;
    req_type[2*ReqDtlb +: 2] = AccR;
    req_priv = '0;
    e_match = 16'h0001; e_fail = '0; e_lock = '0; e_active = 16'h0001;
    req_vld = 3'b010;
    @(negedge clk);
    n_checks++; if (req_rdy !== 3'b010) begin n_errors++; $display("FAIL dtlb_rdy got %b want 010", req_rdy); end
    tick();
    req_vld = '0;
    @(negedge clk);
    n_checks++; if (check_vld !== 1'b1) begin n_errors++; $display("FAIL dtlb_check_vld got %b want 1", check_vld); end
    n_checks++; if (check_paddr !== 56'h8000_0000) begin n_errors++; $display("FAIL dtlb_paddr got %h want 80000000", check_paddr); end
    n_checks++; if (check_type !== 2'd0) begin n_errors++; $display("FAIL dtlb_type got %0d want 0", check_type); end
    n_checks++; if (resp_vld !== 1'b0) begin n_errors++; $display("FAIL dtlb_resp_early got %b want 0", resp_vld); end
    tick();
    @(negedge clk);
    n_checks++; if (resp_vld !== 1'b1 || resp_id !== 2'd1 || resp_fault !== 1'b0) begin
      n_errors++; $display("FAIL dtlb_resp got vld=%b id=%0d fault=%b want 1/1/0", resp_vld, resp_id, resp_fault); end
    tick();
    @(negedge clk);
    n_checks++; if (resp_vld !== 1'b0) begin n_errors++; $display("FAIL dtlb_resp_once got %b want 0", resp_vld); end
  endtask

  task automatic test_round_robin();
    do_reset();
    e_match = '0; e_active = '0; req_priv = 3'b000;
    for (int c = 0; c < 8; c++) begin
      req_vld = (c < 6) ? 3'b111 : 3'b000;
      @(negedge clk);
      if (c < 6) begin
        n_checks++; if (req_rdy !== 3'(1 << (c % 3))) begin
          n_errors++; $display("FAIL rr_grant c=%0d got %b want %b", c, req_rdy, 3'(1 << (c % 3))); end
      end
      if (c >= 2) begin
        n_checks++; if (resp_vld !== 1'b1 || resp_id !== 2'((c - 2) % 3) || resp_fault !== 1'b0) begin
          n_errors++; $display("FAIL rr_resp c=%0d got vld=%b id=%0d fault=%b want 1/%0d/0",
                               c, resp_vld, resp_id, resp_fault, (c - 2) % 3); end
      end else begin
        n_checks++; if (resp_vld !== 1'b0) begin n_errors++; $display("FAIL rr_resp_early c=%0d got %b want 0", c, resp_vld); end
      end
      tick();
    end
  endtask

  task automatic test_lowest_index();
    e_match = 16'h0024; e_fail = 16'h0004; e_lock = '0; e_active = 16'h0024;
    send_one(ReqPtw, AccW, 1'b0);
    n_checks++; if (resp_vld !== 1'b1 || resp_id !== 2'd2 || resp_fault !== 1'b1) begin
      n_errors++; $display("FAIL lowest_idx got vld=%b id=%0d fault=%b want 1/2/1", resp_vld, resp_id, resp_fault); end
  endtask

  task automatic test_priv();
    e_match = 16'h0001; e_fail = 16'h0001; e_lock = '0; e_active = 16'h0001;
    send_one(ReqItlb, AccX, 1'b1);
    n_checks++; if (resp_vld !== 1'b1 || resp_fault !== 1'b0) begin
      n_errors++; $display("FAIL priv_unlocked got vld=%b fault=%b want 1/0", resp_vld, resp_fault); end
    e_lock = 16'h0001;
    send_one(ReqItlb, AccX, 1'b1);
    n_checks++; if (resp_vld !== 1'b1 || resp_fault !== 1'b1) begin
      n_errors++; $display("FAIL priv_locked got vld=%b fault=%b want 1/1", resp_vld, resp_fault); end
    e_match = '0; e_fail = '0; e_lock = '0; e_active = 16'h0080;
    send_one(ReqDtlb, AccR, 1'b0);
    n_checks++; if (resp_vld !== 1'b1 || resp_fault !== 1'b1) begin
      n_errors++; $display("FAIL nomatch_smode got vld=%b fault=%b want 1/1", resp_vld, resp_fault); end
    send_one(ReqDtlb, AccR, 1'b1);
    n_checks++; if (resp_vld !== 1'b1 || resp_fault !== 1'b0) begin
      n_errors++; $display("FAIL nomatch_mmode got vld=%b fault=%b want 1/0", resp_vld, resp_fault); end
  endtask

  task automatic test_backpressure();
    int got_q[$];
    do_reset();
    e_match = '0; e_active = '0;
    for (int c = 0; c < 14; c++) begin
      resp_rdy = !(c >= 3 && c <= 6);
      req_vld  = (c < 10) ? 3'b111 : 3'b000;
      @(negedge clk);
      model_eval();
      n_checks++; if (req_rdy !== exp_rdy) begin n_errors++; $display("FAIL bp_rdy c=%0d got %b want %b", c, req_rdy, exp_rdy); end
      n_checks++; if (resp_vld !== m_s2_v) begin n_errors++; $display("FAIL bp_resp_vld c=%0d got %b want %b", c, resp_vld, m_s2_v); end
      if (c >= 3 && c <= 6) begin
        n_checks++; if (req_rdy !== 3'b000 || check_vld !== 1'b1 || resp_vld !== 1'b1 || resp_id !== 2'd1) begin
          n_errors++; $display("FAIL bp_hold c=%0d got rdy=%b cv=%b rv=%b id=%0d want 000/1/1/1",
                               c, req_rdy, check_vld, resp_vld, resp_id); end
      end
      if (resp_vld === 1'b1 && resp_rdy) got_q.push_back(int'(resp_id));
      tick();
    end
    n_checks++; if (got_q.size() != 6) begin n_errors++; $display("FAIL bp_count got %0d want 6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] != i % 3) begin n_errors++; $display("FAIL bp_order i=%0d got %0d want %0d", i, got_q[i], i % 3); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    e_match = '0; e_active = '0;
    req_vld = 3'b111;
    tick(); tick();
    flush = 1;
    @(negedge clk);
    n_checks++; if (req_rdy !== 3'b000 || check_vld !== 1'b1 || resp_vld !== 1'b1) begin
      n_errors++; $display("FAIL flush_pre got rdy=%b cv=%b rv=%b want 000/1/1", req_rdy, check_vld, resp_vld); end
    tick();
    flush = 0;
    @(negedge clk);
    n_checks++; if (resp_vld !== 1'b0 || check_vld !== 1'b0) begin
      n_errors++; $display("FAIL flush_kill got cv=%b rv=%b want 0/0", check_vld, resp_vld); end
    n_checks++; if (req_rdy !== 3'b100) begin n_errors++; $display("FAIL flush_next_grant got %b want 100", req_rdy); end
    tick();
    req_vld = '0;
    @(negedge clk);
    n_checks++; if (check_vld !== 1'b1 || resp_vld !== 1'b0) begin
      n_errors++; $display("FAIL flush_s1 got cv=%b rv=%b want 1/0", check_vld, resp_vld); end
    tick();
    @(negedge clk);
    n_checks++; if (resp_vld !== 1'b1 || resp_id !== 2'd2) begin
      n_errors++; $display("FAIL flush_resp got vld=%b id=%0d want 1/2", resp_vld, resp_id); end
    tick();
    @(negedge clk);
    n_checks++; if (resp_vld !== 1'b0) begin n_errors++; $display("FAIL flush_tail got %b want 0", resp_vld); end
  endtask

  task automatic test_reset_midop();
    req_vld = 3'b001;
    tick();
    req_vld = '0;
    rstn = 0;
    tick();
    rstn = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if (resp_vld !== 1'b0 || check_vld !== 1'b0) begin
        n_errors++; $display("FAIL midop_reset c=%0d got cv=%b rv=%b want 0/0", c, check_vld, resp_vld); end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_vld = 3'($urandom_range(0, 7));
      for (int i = 0; i < RN; i++) begin
        req_paddr[i*PW +: PW] = PW'({$urandom, $urandom});
        req_type[2*i +: 2]    = 2'($urandom_range(0, 2));
      end
      req_priv = 3'($urandom);
      flush    = ($urandom_range(0, 15) == 0);
      resp_rdy = ($urandom_range(0, 3) != 0);
      e_match  = 16'($urandom) & 16'($urandom) & 16'($urandom);
      e_fail   = 16'($urandom);
      e_lock   = 16'($urandom);
      e_active = ($urandom_range(0, 3) == 0) ? 16'h0 : (16'($urandom) | e_match);
      @(negedge clk);
      model_eval();
      n_checks++; if (req_rdy !== exp_rdy) begin n_errors++; $display("FAIL rnd_rdy c=%0d got %b want %b", c, req_rdy, exp_rdy); end
      n_checks++; if (check_vld !== m_s1_v) begin n_errors++; $display("FAIL rnd_check_vld c=%0d got %b want %b", c, check_vld, m_s1_v); end
      if (m_s1_v) begin
        n_checks++; if (check_paddr !== m_s1_paddr || check_type !== m_s1_type) begin
          n_errors++; $display("FAIL rnd_check_bus c=%0d got %h/%0d want %h/%0d", c, check_paddr, check_type, m_s1_paddr, m_s1_type); end
      end
      n_checks++; if (resp_vld !== m_s2_v) begin n_errors++; $display("FAIL rnd_resp_vld c=%0d got %b want %b", c, resp_vld, m_s2_v); end
      if (m_s2_v) begin
        n_checks++; if (resp_id !== 2'(m_s2_id) || resp_fault !== m_s2_fault) begin
          n_errors++; $display("FAIL rnd_resp c=%0d got id=%0d fault=%b want id=%0d fault=%b", c, resp_id, resp_fault, m_s2_id, m_s2_fault); end
      end
      tick();
    end
    flush = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    rstn = 0; flush = 0; resp_rdy = 1; req_vld = '0; req_paddr = '0; req_type = '0; req_priv = '0;
    e_match = '0; e_fail = '0; e_lock = '0; e_active = '0;
    m_rr = 0; m_s1_v = 0; m_s2_v = 0; m_s1_priv = 0; m_s2_fault = 0;
    m_s1_paddr = '0; m_s1_type = '0; m_s1_id = 0; m_s2_id = 0;
    #1;
    test_reset();
    test_single_dtlb();
    test_round_robin();
    test_lowest_index();
    test_priv();
    test_backpressure();
    test_flush();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rvh_pmp_check_arb.md
RVH_PMP_CHECK_ARB -- requirements
Module: rvh_pmp_check_arb

Interface
REQ-001 SHALL have parameter PADDR_WIDTH, default 56, physical address width.
REQ-002 SHALL have parameter REQ_NUM, default 3, number of requesters (0=ITLB, 1=DTLB, 2=PTW).
REQ-003 SHALL have parameter PMP_ENTRY_COUNT, default 16, number of PMP entries.
REQ-004 SHALL have ports:
- clk  in  1  clock; single clock domain.
- rstn  in  1  reset; synchronous, active-low.
- flush_i  in  1  kill all in-flight checks.
- req_vld_i  in  REQ_NUM  request valid per requester.
- req_rdy_o  out  REQ_NUM  request accepted, one-hot or zero.
- req_paddr_i  in  REQ_NUM*PADDR_WIDTH  packed physical addresses.
- req_access_type_i  in  2*REQ_NUM  packed access type: 0=R, 1=W, 2=X.
- req_priv_m_i  in  REQ_NUM  requester is in M-mode.
- check_vld_o  out  1  broadcast check valid to all entries.
- check_paddr_o  out  PADDR_WIDTH  broadcast address.
- check_access_type_o  out  2  broadcast access type.
- entry_match_i  in  PMP_ENTRY_COUNT  per-entry range hit.
- entry_fail_i  in  PMP_ENTRY_COUNT  per-entry hit with R/W/X deny.
- entry_locked_i  in  PMP_ENTRY_COUNT  per-entry L bit.
- entry_active_i  in  PMP_ENTRY_COUNT  per-entry A != OFF.
- resp_vld_o  out  1  response valid.
- resp_rdy_i  in  1  response consumer ready.
- resp_id_o  out  clog2(REQ_NUM)  requester index of the response.
- resp_fault_o  out  1  access fault.

Function
REQ-005 SHALL grant at most one requester per cycle, round-robin: search starts at rr_ptr; after a handshake, rr_ptr = granted index+1, modulo REQ_NUM.
REQ-006 SHALL form the handshake as req_vld_i[i] & req_rdy_o[i]; req_rdy_o SHALL be asserted only for the granted requester, and only when S1 is empty or advancing and flush_i=0.
REQ-007 SHALL capture the accepted request (paddr, type, priv_m, id) into stage S1 on the handshake edge.
REQ-008 SHALL drive check_vld_o=S1 valid and check_paddr_o/check_access_type_o from the S1 registers only, never from requester inputs.
REQ-009 SHALL, while S1 is valid, select the lowest-index set bit of entry_match_i as the winning entry.
REQ-010 SHALL compute fault when a match exists as entry_fail_i[w] & (~priv_m | entry_locked_i[w]).
REQ-011 SHALL compute fault when no match exists as ~priv_m & (|entry_active_i).
REQ-012 SHALL register id and fault into stage S2; S1 advances when S2 is empty or when resp_vld_o & resp_rdy_i.
REQ-013 SHALL have latency 2: accepted in cycle N, check_vld_o in N+1, resp_vld_o in N+2, given resp_rdy_i=1.
REQ-014 SHALL sustain throughput of one check per cycle when resp_rdy_i=1.
REQ-015 SHALL hold resp_vld_o, resp_id_o and resp_fault_o stable while resp_rdy_i=0, stalling S1 and deasserting all req_rdy_o once S1 is full.
REQ-016 SHALL invalidate S1 and S2 on flush_i=1 and accept nothing that cycle; flush_i takes priority over a simultaneous handshake or resp_rdy_i.
REQ-017 SHALL leave rr_ptr unchanged in cycles without a handshake.
REQ-018 SHALL compute resp_id_o width as max(1, clog2(REQ_NUM)).

Reset
REQ-019 SHALL, when rstn=0 at a clk edge, set S1 and S2 invalid and rr_ptr=0.
REQ-020 SHALL, during and after reset, drive req_rdy_o=0, check_vld_o=0, resp_vld_o=0, resp_fault_o=0, resp_id_o=0, check_paddr_o=0 and check_access_type_o=0.
REQ-021 SHALL discard any in-flight check when reset is asserted mid-operation, with no response issued.

Structure
REQ-022 SHALL take the access-type encodings (R/W/X) and the requester-index constants from the shared rvh_pmp package, also used by the PMP entries.
REQ-023 SHALL use one sub-module, rvh_pmp_rr_arb (parameterised round-robin arbiter with rr_ptr); the lowest-index priority encoder stays inline.

Verification
REQ-024 SHALL cover: single DTLB R, paddr 0x8000_0000, entry 0 matches with R=1, priv_m=0 -> resp_vld_o in cycle N+2, id=1, fault=0.
REQ-025 SHALL cover: all three requesters valid for 6 cycles, resp_rdy_i=1 -> grants in order 0,1,2,0,1,2 and six back-to-back responses.
REQ-026 SHALL cover: entries 2 and 5 both match; entry 2 fails with W, entry 5 allows -> fault=1 (lowest index wins).
REQ-027 SHALL cover: priv_m=1 with failing unlocked entry -> fault=0; the same case with entry_locked_i set -> fault=1; no match, S-mode, one active entry -> fault=1.
REQ-028 SHALL cover: resp_rdy_i=0 for 4 cycles with a continuous request stream -> response held stable, S1 full, req_rdy_o=0, no loss or duplication after release.
REQ-029 SHALL cover: flush_i pulsed with S1 and S2 full and a request pending -> no responses for the killed checks, next accepted request responds 2 cycles after its handshake.
